// File: rtl/pattern_test_controller_pkg.sv
// rtl/pattern_test_controller_pkg.sv - shared types and constants for the pattern test controller
package ptc_pkg;

  localparam int SEED_W = 5;

  // Feedback taps of the XNOR LFSR.
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 2;

  // All-ones never leaves an XNOR LFSR, so that seed is swapped for all-zeros.
  localparam logic [SEED_W-1:0] SEED_LOCKUP = 5'b11111;
  localparam logic [SEED_W-1:0] SEED_SUBST  = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ptc_state_e;

  function automatic logic [SEED_W-1:0] lfsr_next(input logic [SEED_W-1:0] s);
    return {s[SEED_W-2:0], ~(s[TAP_LO] ^ s[TAP_HI])};
  endfunction

  function automatic logic [SEED_W-1:0] seed_fix(input logic [SEED_W-1:0] s);
    return (s == SEED_LOCKUP) ? SEED_SUBST : s;
  endfunction

endpackage

// File: rtl/pattern_test_controller_if.sv
// rtl/pattern_test_controller_if.sv - control and detector-side signal bundle
interface pattern_test_controller_if #(
  parameter int CNT_W = 8
) ();
  import ptc_pkg::*;

  logic              start;
  logic [SEED_W-1:0] seed;
  logic [CNT_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              det_rst;
  logic              det_in;
  logic              det_en;
  logic              det_y;
  logic [CNT_W-1:0]  bit_count;
  logic [CNT_W-1:0]  match_count;

  // Controller side.
  modport slave (
    input  start, seed, length, det_y,
    output busy, done, det_rst, det_in, det_en, bit_count, match_count
  );

  // Test/CSR logic plus the detector.
  modport master (
    output start, seed, length, det_y,
    input  busy, done, det_rst, det_in, det_en, bit_count, match_count
  );

endinterface

// File: rtl/pattern_test_controller_lfsr.sv
// rtl/pattern_test_controller_lfsr.sv - 5-bit XNOR shifter with synchronous load
module ptc_lfsr
  import ptc_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [SEED_W-1:0] seed,
  output logic              out
);

  logic [SEED_W-1:0] lfsr_q;
  logic [SEED_W-1:0] lfsr_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (shift) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q[0];

endmodule

// File: rtl/pattern_test_controller.sv
// rtl/pattern_test_controller.sv - LFSR self-test burst sequencer for the zero_one detector (option: PTC_STOP_ON_MATCH_EN)
module pattern_test_controller
  import ptc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  pattern_test_controller_if.slave   bus
);

  ptc_state_e        state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

  logic              lfsr_load;
  logic              lfsr_shift;
  logic [SEED_W-1:0] lfsr_seed;
  logic              lfsr_bit;
  logic              last_bit;
  logic              count_win;
  logic              hit;

  // Reset forces the LFSR to zero through its load path.
  assign lfsr_load  = ~rst | (state_q == ST_SEED);
  assign lfsr_shift = (state_q == ST_RUN);
  assign lfsr_seed  = ~rst ? '0 : seed_fix(seed_q);

  ptc_lfsr u_lfsr (
    .clk   (clk),
    .load  (lfsr_load),
    .shift (lfsr_shift),
    .seed  (lfsr_seed),
    .out   (lfsr_bit)
  );

  // Y lags its input bit by one cycle, so the first RUN cycle is skipped and DRAIN is included.
  assign count_win = ((state_q == ST_RUN) && (bit_cnt_q != '0)) || (state_q == ST_DRAIN);
  assign hit       = count_win & bus.det_y;
  assign last_bit  = ((bit_cnt_q + CNT_W'(1)) == len_q);

  // Next-state, counter and operand-latch logic.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;

`ifdef PTC_STOP_ON_MATCH_EN
    if (hit && (match_cnt_q == '0)) begin
      match_cnt_d = CNT_W'(1);
    end
`else
    if (hit && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seed_d      = bus.seed;
          len_d       = bus.length;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          state_d     = ST_SEED;
        end
      end
      ST_SEED: begin
        state_d = (len_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
`ifdef PTC_STOP_ON_MATCH_EN
        if (hit) begin
          state_d = ST_DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_d = ST_DRAIN;
          end
        end
`else
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.det_rst     = ~rst | (state_q == ST_SEED);
  assign bus.det_en      = (state_q == ST_RUN);
  assign bus.det_in      = (state_q == ST_RUN) & lfsr_bit;
  assign bus.bit_count   = bit_cnt_q;
  assign bus.match_count = match_cnt_q;

endmodule

// File: doc/pattern_test_controller.md
# pattern_test_controller

Sequencer that runs one self-test burst on the serial pattern detector. On `start` it seeds an internal 5-bit XNOR LFSR, clears the detector, streams `length` pseudo-random bits into it, and counts detector hits. It then reports completion with a one-cycle `done` pulse. It sits between the test/CSR logic and `zero_one_detector`, and replaces bench-driven stimulus with a repeatable hardware burst.

## Interface
- `CNT_W`, 8, width of `length`, `bit_count` and `match_count`
- `SEED_W`, 5, LFSR width; fixed taps [4] and [2]; other values unsupported
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `start`  in  1  begin burst; accepted only in IDLE
- `seed`  in  SEED_W  LFSR seed; sampled on accepted `start`
- `length`  in  CNT_W  bits to stream; sampled on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` through DONE
- `done`  out  1  one-cycle pulse in DONE
- `det_rst`  out  1  active-high clear to detector
- `det_in`  out  1  serial bit to detector input A
- `det_en`  out  1  `det_in` valid this cycle
- `det_y`  in  1  detector output Y
- `bit_count`  out  CNT_W  bits streamed in current/last burst
- `match_count`  out  CNT_W  hits counted in current/last burst, saturating

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN, DONE; encoding lives in the package.
- IDLE:
  - `start` = 1 latches `seed` and `length`, clears both counters, and goes to SEED.
  - `start` is ignored in every other state.
- SEED (1 cycle):
  - `det_rst` = 1.
  - LFSR ← latched seed. Seed 5'b11111 is the XNOR lock-up value and is substituted with 5'b00000.
  - Next state is RUN, or DONE if length = 0.
- RUN:
  - `det_en` = 1 and `det_in` = `lfsr[0]`.
  - LFSR ← {lfsr[3:0], ~(lfsr[2]^lfsr[4])}.
  - `bit_count` increments.
  - Go to DRAIN when `bit_count` + 1 = length.
- DRAIN (1 cycle):
  - `det_en` = 0 and `det_in` = 0.
  - Lets the final bit's Y be sampled.
- `det_y` is counted in RUN cycles after the first RUN cycle and in DRAIN. This accounts for the detector's one-cycle Y latency.
- `match_count` saturates at all-ones.
- DONE (1 cycle): `done` = 1, then IDLE.
- Counters hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE; LFSR 0.
  - `busy`, `done`, `det_en`, `det_in` = 0.
  - `det_rst` = 1 (detector held clear during reset).
  - counters 0.
- Reset mid-burst aborts immediately and applies the reset values above. No `done` is produced.
- Burst latency: accepted `start` to `done` = length + 3 cycles (SEED + length·RUN + DRAIN + DONE).
- For length = 0 the latency is 2 cycles and `match_count` = 0.
- `start` asserted in the same cycle as `done` is ignored. It is accepted one cycle later in IDLE.
- `det_y` is ignored outside the counted windows.

## Configuration
- `PTC_STOP_ON_MATCH_EN` defined:
  - The first counted `det_y` = 1 moves RUN to DRAIN on the next edge, ending the burst early.
  - `bit_count` freezes at the number of bits streamed, giving the index of the first hit.
  - `match_count` ≤ 1.
- Undefined: every burst runs the full `length`, and all hits are counted.

## Structure
- Package `ptc_pkg` holds:
  - the state enum;
  - `SEED_W`;
  - the lock-up constant 5'b11111 and its substitute 5'b00000;
  - the tap positions.
- One sub-module, `ptc_lfsr`, with ports clk, load, shift, seed, out. It is the 5-bit XNOR shifter with synchronous load.
- FSM and counters live in the top module.

## Test plan
- Reset with `rst` = 0 for 2 cycles:
  - all outputs at reset values and `det_rst` = 1;
  - after release, `busy` = 0 until `start`.
- seed 0, length 4, detector model "01", Y one cycle late:
  - `det_in` = 0,1,1,1;
  - `match_count` = 1 and `bit_count` = 4;
  - `done` 7 cycles after `start`.
- seed 5'b11111, length 6:
  - stream identical to seed 0 (0,1,1,1,0,0), so no lock-up;
  - `match_count` = 1.
- length 0: `done` 2 cycles after `start`, `det_en` never high, counters 0.
- `start` held high during a burst → ignored, with exactly one `done` per accepted start. Then `rst` = 0 mid-RUN → IDLE next cycle and no `done`.
- With `PTC_STOP_ON_MATCH_EN`, seed 0, length 20: burst ends after the first hit, `match_count` = 1, `bit_count` = 2.
